// File: rtl/ysyx_22040895_ifu_pcgen_pkg.sv
// rtl/ysyx_22040895_ifu_pcgen_pkg.sv - shared constants, queue-entry layout and FSM states for the PC generator
package ysyx_22040895_ifu_pcgen_pkg;

    localparam int          PKG_XLEN       = 64;
    localparam logic [63:0] PKG_RESET_PC   = 64'h0000_0000_8000_0000;
    localparam int          PKG_INST_BYTES = 4;
    localparam logic [31:0] INST_NOP       = 32'h0000_0013;

    // Instruction-queue entry packed as {pc, inst, misalign}; misalign is bit 0.
    localparam int ENT_MIS_BIT  = 0;
    localparam int ENT_INST_LSB = 1;
    localparam int ENT_PC_LSB   = 33;

    function automatic int ent_width(input int xlen);
        return xlen + 33;
    endfunction

    // RUN issues fetches; MIS_PEND waits to enqueue a misaligned marker; HALT waits for a redirect.
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MIS_PEND = 2'd1,
        ST_HALT     = 2'd2
    } pcgen_state_e;

endpackage

// File: rtl/ysyx_22040895_sync_fifo.sv
// rtl/ysyx_22040895_sync_fifo.sv - synchronous FIFO with flush; head presented combinationally
module ysyx_22040895_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic             full,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    assign do_pop    = pop && !empty;
    // A push into a full FIFO is legal when the head leaves in the same cycle.
    assign do_push   = push && (!full || do_pop);
    assign head_data = mem[rd_ptr];

    // Pointer and occupancy tracking; flush empties the FIFO and wins over push/pop.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage write; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (do_push && !flush && !rst) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/ysyx_22040895_ifu_pcgen.sv
// rtl/ysyx_22040895_ifu_pcgen.sv - PC generator and fetch front-end; optional YSYX_22040895_MISALIGN_CHK_EN
module ysyx_22040895_ifu_pcgen
    import ysyx_22040895_ifu_pcgen_pkg::*;
#(
    parameter int              XLEN       = PKG_XLEN,
    parameter logic [XLEN-1:0] RESET_PC   = XLEN'(PKG_RESET_PC),
    parameter int              INST_BYTES = PKG_INST_BYTES,
    parameter int              DEPTH      = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_pc,
    output logic            req_valid,
    output logic [XLEN-1:0] req_addr,
    input  logic            req_ready,
    input  logic            rsp_valid,
    input  logic [31:0]     rsp_inst,
    output logic            out_valid,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_inst,
    output logic            out_misalign,
    input  logic            out_ready
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = ent_width(XLEN);

    pcgen_state_e    state;
    pcgen_state_e    state_nxt;
    logic [XLEN-1:0] pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   kill_count;

    logic            redir_any;
    logic [XLEN-1:0] sel_pc;
    logic [XLEN-1:0] tgt_pc;
    logic            tgt_mis;
    logic [CW:0]     credit_used;
    logic            credit_ok;
    logic            req_accept;
    logic            rsp_take;
    logic            rsp_keep;
    logic            mark_push;

    logic            ifq_empty;
    logic            ifq_full;
    logic [CW-1:0]   ifq_count;
    logic [XLEN-1:0] ifq_head;

    logic            q_push;
    logic [EW-1:0]   q_push_data;
    logic [EW-1:0]   q_head;
    logic            q_empty;
    logic            q_full;
    logic [CW-1:0]   q_count;
    logic            unused_ok;

    assign redir_any = trap_valid | redirect_valid;
    assign sel_pc    = trap_valid ? trap_pc : redirect_pc;

`ifdef YSYX_22040895_MISALIGN_CHK_EN
    assign tgt_pc    = sel_pc;
    assign tgt_mis   = (sel_pc[1:0] != 2'b00);
    assign unused_ok = ^{ifq_empty, ifq_full, ifq_count};
`else
    assign tgt_pc    = {sel_pc[XLEN-1:2], 2'b00};
    assign tgt_mis   = 1'b0;
    assign unused_ok = ^{ifq_empty, ifq_full, ifq_count, sel_pc[1:0], q_head[ENT_MIS_BIT]};
`endif

    // Killed fetches still hold a credit until their response returns.
    assign credit_used = {1'b0, outstanding} + {1'b0, q_count};
    assign credit_ok   = (credit_used < (CW+1)'(DEPTH));
    assign req_addr    = pc;
    assign req_accept  = req_valid & req_ready;
    assign rsp_take    = rsp_valid & (outstanding != '0);
    assign rsp_keep    = rsp_take & (kill_count == '0);

    // Fetch state register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_RUN;
        else     state <= state_nxt;
    end

    // Next state, request enable and misaligned-marker push; a redirect always re-decides the state.
    always_comb begin
        state_nxt = state;
        req_valid = 1'b0;
        mark_push = 1'b0;
        case (state)
            ST_RUN:      req_valid = credit_ok && !rst;
            ST_MIS_PEND: begin
                mark_push = !q_full;
                if (!q_full) state_nxt = ST_HALT;
            end
            ST_HALT:     state_nxt = ST_HALT;
            default:     state_nxt = ST_RUN;
        endcase
        if (redir_any) state_nxt = tgt_mis ? ST_MIS_PEND : ST_RUN;
    end

    // PC, outstanding and kill bookkeeping; a request accepted alongside a redirect is born killed.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            outstanding <= '0;
            kill_count  <= '0;
        end else begin
            outstanding <= outstanding + CW'(req_accept) - CW'(rsp_take);
            if (redir_any) begin
                kill_count <= outstanding - CW'(rsp_take) + CW'(req_accept);
            end else if (rsp_take && (kill_count != '0)) begin
                kill_count <= kill_count - 1'b1;
            end
            if (redir_any)       pc <= tgt_pc;
            else if (req_accept) pc <= pc + XLEN'(INST_BYTES);
        end
    end

`ifndef SYNTHESIS
    logic [15:0] sim_orphan_rsp_cnt;
    // Count responses that arrive with nothing outstanding (protocol errors) for waveform debug.
    always_ff @(posedge clk) begin
        if (rst)                                  sim_orphan_rsp_cnt <= '0;
        else if (rsp_valid && outstanding == '0)  sim_orphan_rsp_cnt <= sim_orphan_rsp_cnt + 1'b1;
    end
`endif

    ysyx_22040895_sync_fifo #(
        .WIDTH (XLEN),
        .DEPTH (DEPTH)
    ) u_inflight_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redir_any),
        .push      (req_accept & ~redir_any),
        .push_data (pc),
        .pop       (rsp_keep),
        .head_data (ifq_head),
        .empty     (ifq_empty),
        .full      (ifq_full),
        .count     (ifq_count)
    );

    assign q_push      = rsp_keep | mark_push;
    assign q_push_data = mark_push ? {pc, 32'h0, 1'b1} : {ifq_head, rsp_inst, 1'b0};

    ysyx_22040895_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_inst_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (redir_any),
        .push      (q_push),
        .push_data (q_push_data),
        .pop       (out_valid & out_ready),
        .head_data (q_head),
        .empty     (q_empty),
        .full      (q_full),
        .count     (q_count)
    );

    assign out_valid = !q_empty && !rst;
    assign out_pc    = out_valid ? q_head[ENT_PC_LSB +: XLEN] : '0;
    assign out_inst  = out_valid ? q_head[ENT_INST_LSB +: 32] : '0;

`ifdef YSYX_22040895_MISALIGN_CHK_EN
    assign out_misalign = out_valid & q_head[ENT_MIS_BIT];
`else
    assign out_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_22040895_ifu_pcgen.sv
// tb/tb_ysyx_22040895_ifu_pcgen.sv - randomized bench with an epoch-based fetch-stream reference model
module tb_ysyx_22040895_ifu_pcgen;

    localparam int          DEPTH    = 2;
    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        trap_valid = 1'b0;
    logic [63:0] trap_pc = '0;
    logic        req_valid;
    logic [63:0] req_addr;
    logic        req_ready = 1'b0;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_inst = '0;
    logic        out_valid;
    logic [63:0] out_pc;
    logic [31:0] out_inst;
    logic        out_misalign;
    logic        out_ready = 1'b0;

    ysyx_22040895_ifu_pcgen #(
        .XLEN       (64),
        .RESET_PC   (RESET_PC),
        .INST_BYTES (4),
        .DEPTH      (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .trap_valid     (trap_valid),
        .trap_pc        (trap_pc),
        .req_valid      (req_valid),
        .req_addr       (req_addr),
        .req_ready      (req_ready),
        .rsp_valid      (rsp_valid),
        .rsp_inst       (rsp_inst),
        .out_valid      (out_valid),
        .out_pc         (out_pc),
        .out_inst       (out_inst),
        .out_misalign   (out_misalign),
        .out_ready      (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct { logic [63:0] addr; int epoch; } mem_req_t;
    typedef struct { logic [63:0] pc; logic [31:0] inst; logic mis; } q_ent_t;

    // Reference model: memory holds fetches tagged with the epoch they were issued in;
    // a redirect starts a new epoch, so older responses are stale and never reach decode.
    mem_req_t    memq[$];
    q_ent_t      mq[$];
    logic [63:0] m_pc = RESET_PC;
    int          epoch = 0;
    bit          halted = 0;
    bit          mark_pend = 0;
    bit          allow_orphan = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_pops = 0;

    function automatic logic [31:0] inst_of(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h1357_9BDF;
    endfunction

    function automatic bit is_mis(input logic [63:0] t);
`ifdef YSYX_22040895_MISALIGN_CHK_EN
        return t[1:0] != 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [63:0] target_of(input logic [63:0] t);
`ifdef YSYX_22040895_MISALIGN_CHK_EN
        return t;
`else
        return t & ~64'h3;
`endif
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: inputs are already set at the negedge; compare, then advance the model at the posedge.
    task automatic tick();
        bit          exp_rv;
        bit          exp_ov;
        bit          acc;
        bit          popd;
        bit          redir;
        logic [63:0] tgt;
        mem_req_t    r;
        if (rsp_valid && memq.size() == 0 && !allow_orphan) rsp_valid = 1'b0;
        rsp_inst = (memq.size() != 0) ? inst_of(memq[0].addr) : 32'hDEAD_BEEF;
        #1;
        exp_rv = !halted && (memq.size() + mq.size() < DEPTH);
        exp_ov = (mq.size() != 0);
        if (!rst) begin
            check("req_valid", {63'd0, req_valid}, {63'd0, exp_rv});
            check("req_addr", req_addr, m_pc);
            check("out_valid", {63'd0, out_valid}, {63'd0, exp_ov});
            check("out_pc", out_pc, exp_ov ? mq[0].pc : 64'd0);
            check("out_inst", {32'd0, out_inst}, {32'd0, exp_ov ? mq[0].inst : 32'd0});
            check("out_misalign", {63'd0, out_misalign}, {63'd0, exp_ov ? mq[0].mis : 1'b0});
        end
        acc   = !rst && exp_rv && req_ready;
        popd  = !rst && exp_ov && out_ready;
        redir = trap_valid || redirect_valid;
        tgt   = trap_valid ? trap_pc : redirect_pc;
        @(posedge clk);
        if (rst) begin
            memq.delete();
            mq.delete();
            m_pc = RESET_PC;
            epoch++;
            halted = 0;
            mark_pend = 0;
        end else begin
            if (mark_pend && mq.size() < DEPTH) begin
                mq.push_back('{m_pc, 32'h0, 1'b1});
                mark_pend = 0;
            end
            if (popd) begin
                void'(mq.pop_front());
                n_pops++;
            end
            if (rsp_valid && memq.size() != 0) begin
                r = memq.pop_front();
                if (r.epoch == epoch) mq.push_back('{r.addr, inst_of(r.addr), 1'b0});
            end
            if (acc) memq.push_back('{m_pc, epoch});
            if (redir) begin
                epoch++;
                mq.delete();
                m_pc      = target_of(tgt);
                halted    = is_mis(tgt);
                mark_pend = is_mis(tgt);
            end else if (acc) begin
                m_pc = m_pc + 64'd4;
            end
        end
        @(negedge clk);
    endtask

    task automatic cyc(input bit rr, input bit rv, input bit ordy,
                       input bit rd, input logic [63:0] rpc,
                       input bit tv, input logic [63:0] tpc);
        req_ready      = rr;
        rsp_valid      = rv;
        out_ready      = ordy;
        redirect_valid = rd;
        redirect_pc    = rpc;
        trap_valid     = tv;
        trap_pc        = tpc;
        tick();
    endtask

    initial begin
        logic [63:0] t;
        int          p_rr;
        int          p_rsp;
        int          p_or;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) cyc(0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        check("rst_req_addr", req_addr, RESET_PC);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_pc", out_pc, 64'd0);

        // Streaming with one-cycle responses.
        repeat (8) cyc(1, 1, 1, 0, 0, 0, 0);

        // Decode stall fills the queue; one pop re-enables fetch.
        repeat (6) cyc(1, 1, 0, 0, 0, 0, 0);
        check("stall_req_valid", {63'd0, req_valid}, 64'd0);
        cyc(0, 0, 1, 0, 0, 0, 0);
        check("unstall_req_valid", {63'd0, req_valid}, 64'd1);
        repeat (3) cyc(0, 1, 1, 0, 0, 0, 0);

        // Two outstanding fetches killed by a redirect.
        repeat (2) cyc(1, 0, 1, 0, 0, 0, 0);
        cyc(0, 0, 1, 1, 64'h8000_1000, 0, 0);
        check("redir_req_addr", req_addr, 64'h8000_1000);
        repeat (8) cyc(1, 1, 1, 0, 0, 0, 0);

        // Trap beats redirect in the same cycle.
        cyc(0, 1, 1, 1, 64'h8000_3000, 1, 64'h8000_2000);
        check("trap_prio_addr", req_addr, 64'h8000_2000);
        repeat (6) cyc(1, 1, 1, 0, 0, 0, 0);

        // Misaligned redirect target.
        cyc(0, 0, 1, 1, 64'h8000_0102, 0, 0);
`ifdef YSYX_22040895_MISALIGN_CHK_EN
        check("mis_halt", {63'd0, req_valid}, 64'd0);
        cyc(1, 1, 0, 0, 0, 0, 0);
        check("mis_marker", {63'd0, out_misalign}, 64'd1);
        check("mis_pc", out_pc, 64'h8000_0102);
`else
        check("mis_align_addr", req_addr, 64'h8000_0100);
`endif
        repeat (5) cyc(1, 1, 1, 0, 0, 0, 0);
        cyc(0, 1, 1, 1, 64'h8000_0200, 0, 0);
        repeat (4) cyc(1, 1, 1, 0, 0, 0, 0);

        // PC wraps at the top of the address space.
        cyc(0, 1, 1, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0);
        cyc(1, 1, 1, 0, 0, 0, 0);
        check("wrap_addr", req_addr, 64'd0);
        repeat (6) cyc(1, 1, 1, 0, 0, 0, 0);

        // Reset with fetches outstanding and queue occupied; later responses are stale.
        cyc(0, 1, 1, 1, 64'h8000_0000, 0, 0);
        repeat (3) cyc(0, 1, 1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 0);
        rst = 1'b1;
        cyc(0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        check("midrst_req_addr", req_addr, RESET_PC);
        allow_orphan = 1;
        repeat (2) cyc(0, 1, 1, 0, 0, 0, 0);
        allow_orphan = 0;
        check("orphan_out_valid", {63'd0, out_valid}, 64'd0);

        // Randomized phases with varying pressure on each handshake.
        for (int ph = 0; ph < 8; ph++) begin
            p_rr  = $urandom_range(30, 100);
            p_rsp = $urandom_range(20, 100);
            p_or  = $urandom_range(10, 100);
            for (int i = 0; i < 500; i++) begin
                rst = ($urandom_range(0, 999) < 3);
                t = 64'h8000_0000 + {50'd0, 12'($urandom_range(0, 1023)), 2'b00};
                if ($urandom_range(0, 4) == 0) t = t + 64'($urandom_range(1, 3));
                req_ready      = ($urandom_range(0, 99) < p_rr);
                rsp_valid      = ($urandom_range(0, 99) < p_rsp);
                out_ready      = ($urandom_range(0, 99) < p_or);
                redirect_valid = ($urandom_range(0, 99) < 4);
                redirect_pc    = t;
                trap_valid     = ($urandom_range(0, 99) < 2);
                trap_pc        = t ^ 64'h40;
                tick();
            end
            rst = 1'b0;
        end
        check("progress", {63'd0, n_pops > 100}, 64'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ysyx_22040895_ifu_pcgen.md
Name: ysyx_22040895_ifu_pcgen

Overview:
Parametrised PC generator and fetch front-end. It replaces the single-register PC with a unit that has redirect priority, a fetch-request handshake, in-order response tracking and an instruction queue toward decode. It sits between the PC-select logic (branch/jump redirect from EXU, trap vector from CSR unit), the instruction memory port and the IDU. Flushes discard responses that are already in flight.

Parameters:
XLEN, 64, address/PC width
RESET_PC, 64'h0000_0000_8000_0000, PC value after reset
INST_BYTES, 4, sequential increment
DEPTH, 2, instruction-queue entries and also the maximum number of outstanding fetches (power of two, 2..8)

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
redirect_valid  in  1  branch/jump redirect from EXU
redirect_pc  in  XLEN  redirect target
trap_valid  in  1  trap/mret redirect from CSR unit
trap_pc  in  XLEN  trap target
req_valid  out  1  fetch request valid
req_addr  out  XLEN  fetch address
req_ready  in  1  memory accepts request
rsp_valid  in  1  fetch response; always accepted, in order
rsp_inst  in  32  fetched instruction
out_valid  out  1  queue head valid to IDU
out_pc  out  XLEN  PC of head instruction
out_inst  out  32  head instruction
out_misalign  out  1  head is a misaligned-fetch marker (0 unless the feature is enabled)
out_ready  in  1  IDU consumes head

Behaviour:
- Reset (synchronous, rst=1 at a clk edge) clears all state:
  - pc=RESET_PC; req_valid=0; out_valid=0; out_misalign=0; out_pc=0; out_inst=0.
  - Outstanding count, kill count and queue pointers all 0.
- First request: req_valid=1 with req_addr=RESET_PC in the first cycle after rst deasserts.
- req_addr always equals the pc register.
- Request issue:
  - req_valid=1 iff not halted and (outstanding + queue_count) < DEPTH.
  - A request is accepted when req_valid & req_ready. On acceptance the issued pc is pushed into an in-flight PC FIFO, outstanding increments, and pc <= pc + INST_BYTES (XLEN wrap-around, no saturation).
- Response handling:
  - On rsp_valid with kill_count == 0: pop the in-flight PC and push {pc, rsp_inst} into the queue.
  - On rsp_valid with kill_count > 0: drop the response and decrement kill_count.
  - Either way outstanding decrements.
  - A response with nothing outstanding is a protocol error; it is ignored and flagged only in simulation.
- Queue behaviour:
  - Head presented combinationally from the queue.
  - Pop on out_valid & out_ready.
  - Push and pop in the same cycle is allowed when full.
  - The credit rule guarantees no overflow.
- Redirect priority, evaluated in a single cycle: trap_valid > redirect_valid > sequential.
  - On trap or redirect: pc <= target; the queue is flushed (out_valid=0 next cycle); kill_count <= outstanding minus any response arriving this cycle; the in-flight FIFO is cleared.
  - A request accepted in the same cycle as a redirect is counted as killed and the target pc is not incremented.
  - Halt is cleared.
  - The new target is requested no earlier than the next cycle (1-cycle redirect penalty).
- Latency: an instruction appears on out_* one cycle after its rsp_valid.
- Reset mid-operation drops all queue, in-flight and kill state. Any responses that arrive after reset are treated as not outstanding and ignored; the memory side must also be reset.

Optional Feature:
Macro YSYX_22040895_MISALIGN_CHK_EN.
- Enabled: a redirect or trap target with target[1:0] != 0 issues no request. Instead, once the queue has space, a single entry {target, 32'h0, out_misalign=1} is pushed and the unit halts (req_valid=0) until the next redirect or trap.
- Disabled: targets are aligned by forcing bits [1:0] to 0; out_misalign is tied to 0.

Decomposition:
- Shared package/define file holds: XLEN default, RESET_PC, INST_BYTES, the 32-bit NOP constant, and the queue-entry field layout {pc, inst, misalign}.
- One natural sub-module: ysyx_22040895_sync_fifo (parametrised width/depth, flush input). It is instantiated twice: once for the in-flight PC FIFO and once for the instruction queue.

Test Plan:
- Reset then req_ready=1, 1-cycle response latency, out_ready=1 -> req_addr sequence 0x80000000, 0x80000004, 0x80000008; out_pc follows one cycle after each response.
- out_ready=0 with DEPTH=2 -> after two accepted requests req_valid=0; raise out_ready -> one pop re-enables req_valid the next cycle.
- Two requests outstanding, then redirect_valid with redirect_pc=0x80001000 -> both later responses dropped; the next out_pc is 0x80001000.
- trap_valid (trap_pc=0x80002000) and redirect_valid (0x80003000) in the same cycle -> next req_addr=0x80002000.
- Enabled build, redirect_pc=0x80000102 -> out_valid with out_misalign=1, out_pc=0x80000102; req_valid stays 0 until the next redirect. Disabled build -> req_addr=0x80000100.
- Assert rst while two fetches are outstanding and the queue is full -> out_valid=0 and req_addr=RESET_PC after release; stale responses are ignored.
